flag_bank_cond: RTL and testbench

Parametrised successor to the single-context NZVC flag register that sits between the ALU and branch logic. It holds NUM_CTX independent flag contexts and keeps same-cycle forwarding of ALU flags and the CBZ zero bypass. It adds a registered ARMv8 condition-code evaluator for B.cond and a bounded save/restore stack for flag contexts. It feeds the branch-decision stage of the pipelined CPU.

---
 rtl/flag_pkg.sv | 54 +++++
 rtl/flag_stack.sv | 53 +++++
 rtl/flag_bank_cond.sv | 94 +++++++++
 tb/tb_flag_bank_cond.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// Shared NZVC flag types and the ARMv8 condition-code evaluator.
package flag_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_t;

  function automatic logic cond_eval(flags_t f, cond_t c);
    logic r;
    r = 1'b1;
    unique case (c)
      EQ: r = f.z;
      NE: r = !f.z;
      CS: r = f.c;
      CC: r = !f.c;
      MI: r = f.n;
      PL: r = !f.n;
      VS: r = f.v;
      VC: r = !f.v;
      HI: r = f.c && !f.z;
      LS: r = !f.c || f.z;
      GE: r = (f.n == f.v);
      LT: r = (f.n != f.v);
      GT: r = !f.z && (f.n == f.v);
      LE: r = f.z || (f.n != f.v);
      AL: r = 1'b1;
      NV: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flag_stack.sv
// Bounded LIFO of flag contexts with sticky misuse detection.
module flag_stack
  import flag_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  flags_t din,
  output flags_t top,
  output logic   pop_ok,
  output logic   full,
  output logic   empty,
  output logic   err
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  flags_t         mem [DEPTH];
  logic [PW-1:0]  cnt;
  logic           push_ok;
  logic           bad;

  assign full    = (cnt == PW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !pop && !full;
  assign pop_ok  = pop && !push && !empty;
  assign top     = empty ? '0 : mem[IW'(cnt - 1'b1)];

  // simultaneous push/pop is rejected rather than treated as a swap
  assign bad = (push && pop)
             || (push && !pop && full)
             || (pop && !push && empty);

  always_ff @(posedge clk) begin
    if (push_ok && reset) mem[IW'(cnt)] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (push_ok) cnt <= cnt + 1'b1;
      else if (pop_ok) cnt <= cnt - 1'b1;
      if (bad) err <= 1'b1;
    end
  end

endmodule

// File: rtl/flag_bank_cond.sv
// Multi-context NZVC flag bank with forwarding, CBZ bypass and B.cond eval.
// Define FLAG_STACK_EN to build in the save/restore stack.
module flag_bank_cond
  import flag_pkg::*;
#(
  parameter int NUM_CTX     = 2,
  parameter int STACK_DEPTH = 4,
  localparam int CW = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_flag,
  input  logic [CW-1:0] wr_ctx,
  input  logic [3:0]    flags_in,
  input  logic          cbz_zero,
  input  logic [CW-1:0] rd_ctx,
  output logic [3:0]    flags_out,
  output logic          zero_out,
  input  logic          cond_valid,
  input  logic [3:0]    cond,
  output logic          cond_true,
  output logic          cond_true_valid,
  input  logic          push,
  input  logic          pop,
  output logic          stack_full,
  output logic          stack_empty,
  output logic          err
);

  function automatic logic [CW-1:0] ctx_sel(logic [CW-1:0] i);
    return (int'(i) < NUM_CTX) ? i : '0;
  endfunction

  flags_t        ctx_q [NUM_CTX];
  flags_t        fin;
  flags_t        fwd_rd;
  flags_t        stack_top;
  logic          pop_ok;
  logic [CW-1:0] wr;
  logic [CW-1:0] rd;

  assign fin = flags_t'(flags_in);
  assign wr  = ctx_sel(wr_ctx);
  assign rd  = ctx_sel(rd_ctx);

  assign fwd_rd    = (set_flag && wr == rd) ? fin : ctx_q[rd];
  assign flags_out = fwd_rd;
  assign zero_out  = cbz_zero ? fin.z : fwd_rd.z;

`ifdef FLAG_STACK_EN
  flags_t push_data;

  assign push_data = set_flag ? fin : ctx_q[wr];

  flag_stack #(
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .din    (push_data),
    .top    (stack_top),
    .pop_ok (pop_ok),
    .full   (stack_full),
    .empty  (stack_empty),
    .err    (err)
  );
`else
  logic unused_stack_req;

  assign unused_stack_req = push ^ pop;
  assign stack_top   = '0;
  assign pop_ok      = 1'b0;
  assign stack_full  = 1'b0;
  assign stack_empty = 1'b1;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CTX; i++) ctx_q[i] <= '0;
      cond_true       <= 1'b0;
      cond_true_valid <= 1'b0;
    end else begin
      // a restore overrides an ALU write to the same context
      if (pop_ok) ctx_q[wr] <= stack_top;
      else if (set_flag) ctx_q[wr] <= fin;
      cond_true_valid <= cond_valid;
      if (cond_valid) cond_true <= cond_eval(fwd_rd, cond_t'(cond));
    end
  end

endmodule

// File: tb/tb_flag_bank_cond.sv
// Randomised and directed check of flag_bank_cond against a behavioural model.
module tb_flag_bank_cond;

  localparam int NUM_CTX = 2;
  localparam int DEPTH   = 4;
  localparam int CW      = 1;

  logic          clk;
  logic          reset;
  logic          set_flag;
  logic [CW-1:0] wr_ctx;
  logic [3:0]    flags_in;
  logic          cbz_zero;
  logic [CW-1:0] rd_ctx;
  logic [3:0]    flags_out;
  logic          zero_out;
  logic          cond_valid;
  logic [3:0]    cond;
  logic          cond_true;
  logic          cond_true_valid;
  logic          push;
  logic          pop;
  logic          stack_full;
  logic          stack_empty;
  logic          err;

  flag_bank_cond #(
    .NUM_CTX     (NUM_CTX),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .set_flag        (set_flag),
    .wr_ctx          (wr_ctx),
    .flags_in        (flags_in),
    .cbz_zero        (cbz_zero),
    .rd_ctx          (rd_ctx),
    .flags_out       (flags_out),
    .zero_out        (zero_out),
    .cond_valid      (cond_valid),
    .cond            (cond),
    .cond_true       (cond_true),
    .cond_true_valid (cond_true_valid),
    .push            (push),
    .pop             (pop),
    .stack_full      (stack_full),
    .stack_empty     (stack_empty),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model state
  logic [3:0] m_ctx [NUM_CTX];
  logic [3:0] m_stk [$];
  logic       m_err;
  logic       m_ct;
  logic       m_ctv;
  bit         known;

  int n_vec;
  int n_bad;

`ifdef FLAG_STACK_EN
  localparam bit HAS_STACK = 1'b1;
`else
  localparam bit HAS_STACK = 1'b0;
`endif

  function automatic int mc(logic [CW-1:0] x);
    return (int'(x) < NUM_CTX) ? int'(x) : 0;
  endfunction

  function automatic logic [3:0] fwd(int c);
    return (set_flag && mc(wr_ctx) == c) ? flags_in : m_ctx[c];
  endfunction

  // ARM pseudocode style: base test from cond[3:1], inverted by cond[0]
  function automatic logic ref_cond(logic [3:0] f, logic [3:0] c);
    logic n, z, v, k, b;
    {n, z, v, k} = f;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = k;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = k && !z;
      3'd5: b = (n == v);
      3'd6: b = (n == v) && !z;
      default: b = 1'b1;
    endcase
    if (c[0] && c != 4'hF) b = !b;
    return b;
  endfunction

  task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic settle();
    logic [3:0] f;
    @(negedge clk);
    n_vec++;
    if (known) begin
      f = fwd(mc(rd_ctx));
      chk("flags_out", flags_out, f);
      chk("zero_out", {3'b0, zero_out}, {3'b0, cbz_zero ? flags_in[2] : f[2]});
      chk("cond_true_valid", {3'b0, cond_true_valid}, {3'b0, m_ctv});
      chk("cond_true", {3'b0, cond_true}, {3'b0, m_ct});
      chk("stack_full", {3'b0, stack_full},
          {3'b0, HAS_STACK && m_stk.size() == DEPTH});
      chk("stack_empty", {3'b0, stack_empty}, {3'b0, m_stk.size() == 0});
      chk("err", {3'b0, err}, {3'b0, m_err});
    end
  endtask

  task automatic adv();
    int         w;
    logic [3:0] pd;
    logic [3:0] frd;
    bit         popped;
    w = mc(wr_ctx);
    pd = fwd(w);
    frd = fwd(mc(rd_ctx));
    popped = 0;
    if (!reset) begin
      foreach (m_ctx[i]) m_ctx[i] = 4'b0;
      m_stk.delete();
      m_err = 0;
      m_ct = 0;
      m_ctv = 0;
      known = 1;
    end else begin
      if (HAS_STACK) begin
        if (push && pop) m_err = 1;
        else if (push) begin
          if (m_stk.size() == DEPTH) m_err = 1;
          else m_stk.push_back(pd);
        end else if (pop) begin
          if (m_stk.size() == 0) m_err = 1;
          else begin
            m_ctx[w] = m_stk.pop_back();
            popped = 1;
          end
        end
      end
      if (!popped && set_flag) m_ctx[w] = flags_in;
      m_ctv = cond_valid;
      if (cond_valid) m_ct = ref_cond(frd, cond);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1; set_flag = 0; wr_ctx = '0; flags_in = '0; cbz_zero = 0;
    rd_ctx = '0; cond_valid = 0; cond = '0; push = 0; pop = 0;
  endtask

  logic [3:0] vals [4];

  initial begin
    n_vec = 0;
    n_bad = 0;
    known = 0;
    vals[0] = 4'h3; vals[1] = 4'h9; vals[2] = 4'h6; vals[3] = 4'hC;
    idle();
    reset = 0;
    @(posedge clk);
    #1;
    settle(); adv();

    // reset state, then same-cycle forwarding
    idle();
    set_flag = 1; flags_in = 4'b1010;
    settle();
    chk("lit_fwd", flags_out, 4'b1010);
    chk("lit_rst_empty", {3'b0, stack_empty}, 4'h1);
    chk("lit_rst_full", {3'b0, stack_full}, 4'h0);
    chk("lit_rst_err", {3'b0, err}, 4'h0);
    chk("lit_rst_ctv", {3'b0, cond_true_valid}, 4'h0);
    adv();
    idle();
    settle();
    chk("lit_stored", flags_out, 4'b1010);
    adv();

    // other context write and CBZ bypass
    set_flag = 1; wr_ctx = 1; flags_in = 4'b0100; cbz_zero = 1;
    settle();
    chk("lit_ctx_iso", flags_out, 4'b1010);
    chk("lit_cbz", {3'b0, zero_out}, 4'h1);
    adv();

    // condition evaluation on N=1,Z=0,V=0,C=0
    idle();
    set_flag = 1; flags_in = 4'b1000;
    settle(); adv();
    idle();
    cond_valid = 1; cond = 4'b1010;
    settle(); adv();
    cond = 4'b1011;
    settle();
    chk("lit_ge", {3'b0, cond_true}, 4'h0);
    chk("lit_ge_v", {3'b0, cond_true_valid}, 4'h1);
    adv();
    cond = 4'b1111;
    settle();
    chk("lit_lt", {3'b0, cond_true}, 4'h1);
    adv();
    cond_valid = 0; cond = 4'b0000;
    settle();
    chk("lit_nv", {3'b0, cond_true}, 4'h1);
    adv();
    settle();
    chk("lit_hold", {3'b0, cond_true}, 4'h1);
    chk("lit_hold_v", {3'b0, cond_true_valid}, 4'h0);
    adv();

`ifdef FLAG_STACK_EN
    for (int i = 0; i < 4; i++) begin
      idle(); set_flag = 1; flags_in = vals[i]; push = 1;
      settle(); adv();
    end
    idle();
    push = 1;
    settle();
    chk("lit_full", {3'b0, stack_full}, 4'h1);
    adv();
    idle();
    settle();
    chk("lit_ovf_err", {3'b0, err}, 4'h1);
    adv();
    for (int i = 0; i < 4; i++) begin
      idle(); pop = 1;
      settle(); adv();
      idle();
      settle();
      chk("lit_pop_order", flags_out, vals[3 - i]);
      adv();
    end
    idle(); pop = 1;
    settle(); adv();
    idle();
    settle();
    chk("lit_unf_err", {3'b0, err}, 4'h1);
    chk("lit_unf_empty", {3'b0, stack_empty}, 4'h1);
    adv();
    // pop beats set_flag on the same context
    idle(); set_flag = 1; flags_in = 4'b0011; push = 1;
    settle(); adv();
    idle(); set_flag = 1; flags_in = 4'b1111; pop = 1;
    settle(); adv();
    idle();
    settle();
    chk("lit_pop_wins", flags_out, 4'b0011);
    adv();
    // full -> pop -> push is legal
    idle(); reset = 0;
    settle(); adv();
    for (int i = 0; i < 4; i++) begin
      idle(); push = 1; set_flag = 1; flags_in = vals[i];
      settle(); adv();
    end
    idle(); pop = 1;
    settle(); adv();
    idle(); push = 1;
    settle(); adv();
    idle();
    settle();
    chk("lit_fpp_err", {3'b0, err}, 4'h0);
    chk("lit_fpp_full", {3'b0, stack_full}, 4'h1);
    adv();
`else
    idle(); set_flag = 1; flags_in = 4'b0110;
    settle(); adv();
    for (int i = 0; i < 4; i++) begin
      idle(); push = (i % 2 == 0); pop = (i % 2 == 1);
      settle(); adv();
    end
    idle();
    settle();
    chk("lit_nostk_ctx", flags_out, 4'b0110);
    chk("lit_nostk_empty", {3'b0, stack_empty}, 4'h1);
    chk("lit_nostk_err", {3'b0, err}, 4'h0);
    adv();
`endif

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 60) != 0);
      set_flag   = $urandom_range(0, 1);
      wr_ctx     = CW'($urandom);
      rd_ctx     = CW'($urandom);
      flags_in   = 4'($urandom);
      cbz_zero   = ($urandom_range(0, 3) == 0);
      cond_valid = $urandom_range(0, 1);
      cond       = 4'($urandom);
      push       = ($urandom_range(0, 2) == 0);
      pop        = ($urandom_range(0, 2) == 0);
      settle();
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
